// File: rtl/crc8_frame_checker.sv
// rtl/crc8_frame_checker.sv - sync-hunting, length-prefixed CRC-8 frame checker
// Optional inter-byte timeout compiled in with macro CRC8_TIMEOUT_EN.
module crc8_frame_checker #(
   parameter int MAX_LEN        = 16,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic [7:0] pay_out,
   output logic       pay_valid,
   output logic       pay_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       busy
);

   typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CRC} state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   // Whole-byte fold of poly 0x07, MSB first, so one byte per cycle is absorbed.
   function automatic logic [7:0] crc8_fold(input logic [7:0] crc_in, input logic [7:0] b);
      logic [7:0] c;
      c = crc_in ^ b;
      for (int i = 0; i < 8; i++)
         c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
      return c;
   endfunction

   state_t     state, state_next;
   logic [7:0] crc, crc_next;
   logic [7:0] count, count_next;
   logic [7:0] pay_out_next;
   logic       pay_valid_next, pay_last_next;
   logic       frame_ok_next, frame_err_next;
   logic [1:0] err_code_next;
   logic       busy_next;

`ifdef CRC8_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] timer, timer_next;
`endif

   always_comb begin
      state_next     = state;
      crc_next       = crc;
      count_next     = count;
      pay_out_next   = pay_out;
      pay_valid_next = 1'b0;
      pay_last_next  = 1'b0;
      frame_ok_next  = 1'b0;
      frame_err_next = 1'b0;
      err_code_next  = err_code;
`ifdef CRC8_TIMEOUT_EN
      timer_next     = '0;
`endif
      case (state)
         S_IDLE: begin
            if (data_valid && data_in == SYNC_BYTE) begin
               state_next = S_LEN;
               crc_next   = 8'h00;
            end
         end
         S_LEN: begin
            if (data_valid) begin
               if (data_in == 8'd0 || data_in > MAX_LEN_B) begin
                  frame_err_next = 1'b1;
                  err_code_next  = 2'b01;
                  state_next     = S_IDLE;
               end else begin
                  count_next = data_in;
                  crc_next   = crc8_fold(crc, data_in);
                  state_next = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (data_valid) begin
               crc_next       = crc8_fold(crc, data_in);
               pay_out_next   = data_in;
               pay_valid_next = 1'b1;
               count_next     = count - 8'd1;
               if (count == 8'd1) begin
                  pay_last_next = 1'b1;
                  state_next    = S_CRC;
               end
            end
         end
         S_CRC: begin
            if (data_valid) begin
               if (data_in == crc) begin
                  frame_ok_next = 1'b1;
               end else begin
                  frame_err_next = 1'b1;
                  err_code_next  = 2'b10;
               end
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
`ifdef CRC8_TIMEOUT_EN
      // An accepted byte always clears the timer, so a byte on the expiry cycle wins.
      if (state != S_IDLE && !data_valid) begin
         if (timer == TIMER_LAST) begin
            frame_err_next = 1'b1;
            err_code_next  = 2'b11;
            state_next     = S_IDLE;
         end else begin
            timer_next = timer + 1'b1;
         end
      end
`endif
      busy_next = (state_next != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         crc       <= 8'h00;
         count     <= 8'h00;
         pay_out   <= 8'h00;
         pay_valid <= 1'b0;
         pay_last  <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'b00;
         busy      <= 1'b0;
`ifdef CRC8_TIMEOUT_EN
         timer     <= '0;
`endif
      end else begin
         state     <= state_next;
         crc       <= crc_next;
         count     <= count_next;
         pay_out   <= pay_out_next;
         pay_valid <= pay_valid_next;
         pay_last  <= pay_last_next;
         frame_ok  <= frame_ok_next;
         frame_err <= frame_err_next;
         err_code  <= err_code_next;
         busy      <= busy_next;
`ifdef CRC8_TIMEOUT_EN
         timer     <= timer_next;
`endif
      end
   end

endmodule

// File: tb/tb_crc8_frame_checker.sv
// tb/tb_crc8_frame_checker.sv - scoreboard bench for crc8_frame_checker
module tb_crc8_frame_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       data_valid = 1'b0;
   logic [7:0] pay_out;
   logic       pay_valid, pay_last, frame_ok, frame_err, busy;
   logic [1:0] err_code;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct packed {
      logic [1:0] kind;   // 0 payload, 1 ok, 2 err
      logic [7:0] data;
      logic       last;
      logic [1:0] code;
      int         when;
   } ev_t;

   ev_t sb[$];

   crc8_frame_checker #(.MAX_LEN(16), .TIMEOUT_CYCLES(20)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .pay_out(pay_out), .pay_valid(pay_valid), .pay_last(pay_last),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] crc8_model(input logic [7:0] bytes[$]);
      logic [7:0] c = 8'h00;
      logic fb;
      foreach (bytes[k])
         for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ bytes[k][i];
            c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
         end
      return c;
   endfunction

   // Monitor: every output event must match the head of the scoreboard, including arrival cycle.
   always @(negedge clk) begin
      if (!reset && (pay_valid || frame_ok || frame_err)) begin
         ev_t obs, exp;
         if (frame_ok && frame_err) begin
            checks++; failures++;
            $display("FAIL ok_err_exclusive got frame_ok=1 frame_err=1 required not both");
         end
         obs.kind = pay_valid ? 2'd0 : (frame_ok ? 2'd1 : 2'd2);
         obs.data = pay_valid ? pay_out : 8'h00;
         obs.last = pay_valid ? pay_last : 1'b0;
         obs.code = frame_err ? err_code : 2'b00;
         obs.when = cyc;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected got kind=%0d data=%02h last=%0b code=%0d cyc=%0d required no event",
                     obs.kind, obs.data, obs.last, obs.code, obs.when);
         end else begin
            exp = sb.pop_front();
            if (obs !== exp) begin
               failures++;
               $display("FAIL sb_event got kind=%0d data=%02h last=%0b code=%0d cyc=%0d required kind=%0d data=%02h last=%0b code=%0d cyc=%0d",
                        obs.kind, obs.data, obs.last, obs.code, obs.when,
                        exp.kind, exp.data, exp.last, exp.code, exp.when);
            end
         end
      end
   end

   task automatic put(input logic [7:0] b);
      @(posedge clk); #1;
      data_in = b;
      data_valid = 1'b1;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         data_valid = 1'b0;
      end
   endtask

   task automatic exp_pay(input logic [7:0] b, input logic last);
      sb.push_back('{kind: 2'd0, data: b, last: last, code: 2'b00, when: cyc + 1});
   endtask

   task automatic exp_ok();
      sb.push_back('{kind: 2'd1, data: 8'h00, last: 1'b0, code: 2'b00, when: cyc + 1});
   endtask

   task automatic exp_err(input logic [1:0] code, input int dly);
      sb.push_back('{kind: 2'd2, data: 8'h00, last: 1'b0, code: code, when: cyc + dly});
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL %s got %0d pending events required 0", name, sb.size());
         sb.delete();
      end
   endtask

   // Sends a complete, correct frame and queues its expected payload and OK pulse.
   task automatic send_good(input logic [7:0] pl[$]);
      logic [7:0] lb[$];
      lb = pl;
      lb.push_front(8'(pl.size()));
      put(8'hA5);
      put(8'(pl.size()));
      foreach (pl[i]) begin
         put(pl[i]);
         exp_pay(pl[i], i == pl.size() - 1);
      end
      put(crc8_model(lb));
      exp_ok();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({pay_out, pay_valid, pay_last, frame_ok, frame_err, err_code, busy} !== 15'd0) begin
         failures++;
         $display("FAIL reset_state got %h required 0",
                  {pay_out, pay_valid, pay_last, frame_ok, frame_err, err_code, busy});
      end
      reset = 1'b0;
   endtask

   task automatic test_bad_crc();
      put(8'hA5); put(8'h01); put(8'h00); exp_pay(8'h00, 1'b1);
      put(8'h16); exp_err(2'b10, 1);
      gap(3);
      check_drained("bad_crc_drain");
   endtask

   task automatic test_bad_len();
      put(8'h00); put(8'hFF); put(8'hA5); put(8'h11); exp_err(2'b01, 1);
      put(8'hA5); put(8'h00); exp_err(2'b01, 1);
      gap(4);
      checks++;
      if (err_code !== 2'b01 || frame_err !== 1'b0) begin
         failures++;
         $display("FAIL err_code_hold got code=%0d err=%0b required code=1 err=0", err_code, frame_err);
      end
      check_drained("bad_len_drain");
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] pl[$];
      put(8'hA5); put(8'h03);
      put(8'h10); exp_pay(8'h10, 1'b0);
      put(8'h20); exp_pay(8'h20, 1'b0);
      gap(1);
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_mid_frame got %0b required 1", busy);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({pay_out, pay_valid, pay_last, frame_ok, frame_err, err_code, busy} !== 15'd0) begin
         failures++;
         $display("FAIL reset_mid_frame got %h required 0",
                  {pay_out, pay_valid, pay_last, frame_ok, frame_err, err_code, busy});
      end
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      gap(4);
      check_drained("reset_abort_drain");
      pl = '{8'h00};
      send_good(pl);
      gap(3);
      check_drained("after_reset_drain");
   endtask

   task automatic test_back_to_back();
      logic [7:0] pl[$];
      put(8'hA5);
      put(8'h01);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_rise got %0b required 1", busy);
      end
      put(8'h00); exp_pay(8'h00, 1'b1);
      put(8'h15); exp_ok();
      pl = '{8'h5A, 8'hC3};
      send_good(pl);
      pl = '{8'hA5, 8'hA5};
      send_good(pl);
      gap(1);
      checks++;
      if (busy !== 1'b0 || frame_ok !== 1'b1) begin
         failures++;
         $display("FAIL busy_fall got busy=%0b ok=%0b required busy=0 ok=1", busy, frame_ok);
      end
      gap(3);
      check_drained("back_to_back_drain");
   endtask

   task automatic test_max_len();
      logic [7:0] pl[$];
      for (int i = 0; i < 16; i++) pl.push_back(8'($urandom_range(0, 255)));
      send_good(pl);
      gap(3);
      check_drained("max_len_drain");
   endtask

   task automatic test_gaps();
      logic [7:0] lb[$];
      lb = '{8'h02, 8'h33, 8'h44};
      put(8'hA5); gap(3);
      put(8'h02); gap(5);
      put(8'h33); exp_pay(8'h33, 1'b0); gap(2);
      put(8'h44); exp_pay(8'h44, 1'b1); gap(10);
      put(crc8_model(lb)); exp_ok();
      gap(3);
      check_drained("gaps_drain");
   endtask

`ifdef CRC8_TIMEOUT_EN
   task automatic test_timeout();
      logic [7:0] lb[$];
      put(8'hA5); put(8'h02);
      put(8'h11); exp_pay(8'h11, 1'b0); exp_err(2'b11, 21);
      gap(25);
      check_drained("timeout_drain");
      lb = '{8'h02, 8'h11, 8'h22};
      put(8'hA5); put(8'h02);
      put(8'h11); exp_pay(8'h11, 1'b0);
      gap(19);
      put(8'h22); exp_pay(8'h22, 1'b1);
      put(crc8_model(lb)); exp_ok();
      gap(3);
      check_drained("timeout_edge_drain");
   endtask
`endif

   initial begin
      test_reset();
      test_bad_crc();
      test_bad_len();
      test_reset_mid_frame();
      test_back_to_back();
      test_max_len();
      test_gaps();
`ifdef CRC8_TIMEOUT_EN
      test_timeout();
`endif
      gap(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
